// File: rtl/uart_tx_arbiter_if.sv
// Requester lanes and UART transmitter port shared by uart_tx_arbiter.
// The master side is the arbiter; the slave side is requesters plus transmitter.
interface uart_tx_arbiter_if #(
   parameter int NREQ = 4
);
   logic [NREQ-1:0]   req_valid;
   logic [8*NREQ-1:0] req_data;
   logic [NREQ-1:0]   req_last;
   logic [NREQ-1:0]   req_ready;
   logic [7:0]        uart_din;
   logic              uart_wr_en;
   logic              uart_tx_busy;

   modport master (
      input  req_valid,
      input  req_data,
      input  req_last,
      output req_ready,
      output uart_din,
      output uart_wr_en,
      input  uart_tx_busy
   );

   modport slave (
      output req_valid,
      output req_data,
      output req_last,
      input  req_ready,
      input  uart_din,
      input  uart_wr_en,
      output uart_tx_busy
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter between NREQ requesters.
// A grant is held until a byte flagged last is sent or the hold timeout expires.
module uart_tx_arbiter #(
   parameter int NREQ         = 4,
   parameter int HOLD_TIMEOUT = 65535
) (
   input  logic                      clk_50m,
   input  logic                      reset,
   uart_tx_arbiter_if.master         bus,
   output logic [$clog2(NREQ)-1:0]   grant_id,
   output logic                      grant_active
);
   localparam int IW = $clog2(NREQ);
   localparam int HW = $clog2(HOLD_TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE      = 2'd0,
      ISSUE     = 2'd1,
      WAIT_BUSY = 2'd2,
      WAIT_DONE = 2'd3
   } state_t;

   state_t        state;
   state_t        state_nx;
   logic [IW-1:0] ptr;
   logic [IW-1:0] ptr_nx;
   logic [IW-1:0] grant_nx;
   logic          gact_nx;
   logic [HW-1:0] hold_cnt;
   logic [HW-1:0] hold_nx;
   logic          last_q;
   logic          last_nx;
   logic [IW-1:0] pick;
   logic          any_req;
   logic [IW-1:0] gid_inc;
   logic          cur_valid;
   logic          fire;
   logic          hold_done;

   // Scan upward from ptr with wrap; lowest offset from ptr wins.
   always_comb begin
      logic [IW-1:0] idx;
      pick    = ptr;
      any_req = 1'b0;
      idx     = '0;
      for (int k = NREQ - 1; k >= 0; k--) begin
         idx = IW'((int'(ptr) + k) % NREQ);
         if (bus.req_valid[idx]) begin
            pick    = idx;
            any_req = 1'b1;
         end
      end
   end

   // Grant helpers: successor index, fire condition, timeout compare.
   always_comb begin
      gid_inc   = (grant_id == IW'(NREQ - 1)) ? '0 : grant_id + IW'(1);
      cur_valid = bus.req_valid[grant_id];
      fire      = (state == ISSUE) && cur_valid
                  && !bus.uart_tx_busy && !reset;
      hold_done = (hold_cnt == HW'(HOLD_TIMEOUT - 1));
   end

   // Transmitter-side outputs; strobe and ready only on a fire cycle.
   always_comb begin
      bus.uart_din   = bus.req_data[{grant_id, 3'b000} +: 8];
      bus.uart_wr_en = fire;
      bus.req_ready  = '0;
      if (fire) begin
         bus.req_ready[grant_id] = 1'b1;
      end
   end

   // Next-state logic for the grant FSM.
   always_comb begin
      state_nx = state;
      ptr_nx   = ptr;
      grant_nx = grant_id;
      gact_nx  = grant_active;
      hold_nx  = hold_cnt;
      last_nx  = last_q;
      unique case (state)
         IDLE: begin
            if (any_req) begin
               grant_nx = pick;
               gact_nx  = 1'b1;
               hold_nx  = '0;
               state_nx = ISSUE;
            end
         end
         ISSUE: begin
            if (fire) begin
               last_nx  = bus.req_last[grant_id];
               hold_nx  = '0;
               state_nx = WAIT_BUSY;
            end else if (!cur_valid) begin
               if (hold_done) begin
                  ptr_nx   = gid_inc;
                  gact_nx  = 1'b0;
                  state_nx = IDLE;
               end else begin
                  hold_nx = hold_cnt + HW'(1);
               end
            end
         end
         WAIT_BUSY: begin
            if (bus.uart_tx_busy) begin
               state_nx = WAIT_DONE;
            end
         end
         WAIT_DONE: begin
            if (!bus.uart_tx_busy) begin
               if (last_q) begin
                  ptr_nx   = gid_inc;
                  gact_nx  = 1'b0;
                  state_nx = IDLE;
               end else begin
                  state_nx = ISSUE;
               end
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // State and grant registers with synchronous reset.
   always_ff @(posedge clk_50m) begin
      if (reset) begin
         state        <= IDLE;
         ptr          <= '0;
         grant_id     <= '0;
         grant_active <= 1'b0;
         hold_cnt     <= '0;
         last_q       <= 1'b0;
      end else begin
         state        <= state_nx;
         ptr          <= ptr_nx;
         grant_id     <= grant_nx;
         grant_active <= gact_nx;
         hold_cnt     <= hold_nx;
         last_q       <= last_nx;
      end
   end
endmodule
